// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg: shared ALU opcodes, sequencer state encoding and wide-op decode
package cpu_alu_pkg;
  localparam int OPC_DEF_W = 5;
  localparam logic [OPC_DEF_W-1:0] OP_AND = 5'b01010;
  localparam logic [OPC_DEF_W-1:0] OP_OR  = 5'b01011;
  localparam logic [OPC_DEF_W-1:0] OP_MUL = 5'b01110;
  localparam logic [OPC_DEF_W-1:0] OP_DIV = 5'b01111;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPERAND = 3'd1,
    S_CAPTURE = 3'd2,
    S_WB_LO   = 3'd3,
    S_WB_HI   = 3'd4
  } state_t;
  // Only MUL and DIV produce a meaningful upper half; every other code, defined or not, is narrow.
  function automatic logic is_wide(input logic [OPC_DEF_W-1:0] opc);
    return (opc == OP_MUL) || (opc == OP_DIV);
  endfunction
endpackage

// File: rtl/alu_z_capture.sv
// alu_z_capture: load-enabled 2*DATA_W result register with half select onto the write port
//   clk, rst     clock, synchronous active-high reset
//   i_load       capture i_z at this edge
//   i_z          ALU result
//   i_en         write port active; o_data forced to 0 otherwise
//   i_sel_hi     0 = low half, 1 = high half
//   o_data       selected half of the captured result
module alu_z_capture #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [2*DATA_W-1:0] i_z,
  input  logic                i_en,
  input  logic                i_sel_hi,
  output logic [DATA_W-1:0]   o_data
);
  logic [2*DATA_W-1:0] r_z;
  always_ff @(posedge clk) begin
    if (rst) r_z <= '0;
    else if (i_load) r_z <= i_z;
  end
  always_comb o_data = !i_en ? '0 : i_sel_hi ? r_z[2*DATA_W-1:DATA_W] : r_z[DATA_W-1:0];
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: stages one request into held ALU operands, captures Z, writes it back LO then HI
//   clock, clear           clock, synchronous active-high reset
//   start                  request, taken only when idle
//   opcode_in/ra_val/rb_val request contents
//   alu_Y/alu_B/alu_opcode held operands to the ALU; alu_Z its 2*DATA_W result
//   busy                   not idle
//   wr_en/wr_hi/wr_data    one 32-bit write per result half
//   done                   final write cycle of a request
module alu_op_sequencer
  import cpu_alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OPC_W  = OPC_DEF_W
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [OPC_W-1:0]    opcode_in,
  input  logic [DATA_W-1:0]   ra_val,
  input  logic [DATA_W-1:0]   rb_val,
  output logic [DATA_W-1:0]   alu_Y,
  output logic [DATA_W-1:0]   alu_B,
  output logic [OPC_W-1:0]    alu_opcode,
  input  logic [2*DATA_W-1:0] alu_Z,
  output logic                busy,
  output logic                wr_en,
  output logic                wr_hi,
  output logic [DATA_W-1:0]   wr_data,
  output logic                done
);
  state_t r_state, w_next;
  logic   r_wide;
  logic   w_accept;
  assign w_accept = (r_state == S_IDLE) && start;
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state    <= S_IDLE;
      alu_Y      <= '0;
      alu_B      <= '0;
      alu_opcode <= '0;
      r_wide     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        alu_Y      <= ra_val;
        alu_B      <= rb_val;
        alu_opcode <= opcode_in;
        r_wide     <= is_wide(opcode_in);
      end
    end
  end
  always_comb
    w_next = (r_state == S_IDLE)             ? (start ? S_OPERAND : S_IDLE) :
             (r_state == S_OPERAND)          ? S_CAPTURE :
             (r_state == S_CAPTURE)          ? S_WB_LO :
             (r_state == S_WB_LO && r_wide)  ? S_WB_HI : S_IDLE;
  // All outputs decode from registered state so no input reaches an output combinationally.
  always_comb begin
    busy  = r_state != S_IDLE;
    wr_en = (r_state == S_WB_LO) || (r_state == S_WB_HI);
    wr_hi = r_state == S_WB_HI;
    done  = (r_state == S_WB_LO && !r_wide) || (r_state == S_WB_HI);
  end
  alu_z_capture #(.DATA_W(DATA_W)) u_zcap (
    .clk      (clock),
    .rst      (clear),
    .i_load   (r_state == S_CAPTURE),
    .i_z      (alu_Z),
    .i_en     (wr_en),
    .i_sel_hi (wr_hi),
    .o_data   (wr_data)
  );
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed table-driven checks plus multi-cycle corner sequences
module tb_alu_op_sequencer;
  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  opcode_in = '0;
  logic [31:0] ra_val = '0, rb_val = '0;
  logic [31:0] alu_Y, alu_B, wr_data;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_Z;
  logic        busy, wr_en, wr_hi, done;
  int          n_tests = 0, n_fail = 0;

  alu_op_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .opcode_in(opcode_in),
    .ra_val(ra_val), .rb_val(rb_val), .alu_Y(alu_Y), .alu_B(alu_B),
    .alu_opcode(alu_opcode), .alu_Z(alu_Z), .busy(busy), .wr_en(wr_en),
    .wr_hi(wr_hi), .wr_data(wr_data), .done(done)
  );

  always #5 clock = ~clock;

  always_comb begin
    alu_Z = 64'hDEAD_BEEF_1234_5678;
    if (alu_opcode == 5'b01010) alu_Z = {32'h0, alu_Y & alu_B};
    else if (alu_opcode == 5'b01011) alu_Z = {32'h0, alu_Y | alu_B};
    else if (alu_opcode == 5'b01110) alu_Z = 64'h0000_0001_0000_0002;
    else if (alu_opcode == 5'b01111) alu_Z = 64'hAAAA_5555_1111_2222;
  end

  typedef struct {
    logic [4:0]  opc;
    logic [31:0] ra, rb, lo, hi;
    logic        wide;
  } vec_t;
  vec_t vecs[5];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    start = 1'b1; opcode_in = v.opc; ra_val = v.ra; rb_val = v.rb;
    tick;
    start = 1'b0; opcode_in = ~v.opc; ra_val = ~v.ra; rb_val = ~v.rb;
    chk("busy_operand", busy, 1);
    chk("no_wr_operand", wr_en, 0);
    tick;
    chk("no_wr_capture", wr_en, 0);
    tick;
    chk("lo_wr_en", wr_en, 1);
    chk("lo_wr_hi", wr_hi, 0);
    chk("lo_data", wr_data, v.lo);
    chk("lo_done", done, !v.wide);
    tick;
    if (v.wide) begin
      chk("hi_wr_en", wr_en, 1);
      chk("hi_wr_hi", wr_hi, 1);
      chk("hi_data", wr_data, v.hi);
      chk("hi_done", done, 1);
      tick;
    end
    chk("idle_busy", busy, 0);
    chk("idle_wr_en", wr_en, 0);
    chk("idle_wr_data", wr_data, 0);
    chk("held_Y", alu_Y, v.ra);
    chk("held_B", alu_B, v.rb);
    chk("held_opc", alu_opcode, v.opc);
  endtask

  initial begin
    int dones;
    logic [5:0] busy_seq;
    vecs[0] = '{5'b01010, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 32'h0, 1'b0};
    vecs[1] = '{5'b01011, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 32'h0, 1'b0};
    vecs[2] = '{5'b01110, 32'h0000_0005, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 1'b1};
    vecs[3] = '{5'b01111, 32'h0000_0009, 32'h0000_0003, 32'h1111_2222, 32'hAAAA_5555, 1'b1};
    vecs[4] = '{5'b11111, 32'h0000_0001, 32'h0000_0001, 32'h1234_5678, 32'h0, 1'b0};
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_Y", alu_Y, 0);
    // clear and start together while idle: request must be dropped
    start = 1'b1; opcode_in = 5'b01010; ra_val = 32'h5555_AAAA; rb_val = 32'h1234_4321;
    tick;
    start = 1'b0; clear = 1'b0;
    chk("clrstart_busy", busy, 0);
    chk("clrstart_Y", alu_Y, 0);
    chk("clrstart_B", alu_B, 0);
    chk("clrstart_opc", alu_opcode, 0);
    tick;
    chk("clrstart_busy2", busy, 0);
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    // start held for six edges: one request, then a second taken at the first idle edge
    start = 1'b1; opcode_in = 5'b01011; ra_val = 32'h1; rb_val = 32'h2;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      busy_seq[i] = busy;
      if (done) begin
        dones++;
        chk("hold_lo_data", wr_data, 32'h3);
      end
    end
    start = 1'b0;
    chk("hold_done_count", dones, 1);
    chk("hold_busy_seq", busy_seq, 6'b110111);
    tick;
    chk("hold_second_done", done, 1);
    chk("hold_second_data", wr_data, 32'h3);
    tick;
    chk("hold_second_idle", busy, 0);
    // clear in WB_LO of a DIV aborts the HI write
    start = 1'b1; opcode_in = 5'b01111; ra_val = 32'h9; rb_val = 32'h3;
    tick;
    start = 1'b0;
    tick; tick;
    chk("abort_lo_wr", wr_en, 1);
    chk("abort_lo_done", done, 0);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_wr_hi", wr_hi, 0);
    chk("abort_done", done, 0);
    chk("abort_wr_data", wr_data, 0);
    chk("abort_Y", alu_Y, 0);
    tick;
    chk("abort_no_hi", wr_en, 0);
    chk("abort_no_done", done, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
